hazard_pipe: RTL and testbench

HAZARD_PIPE -- requirements
Module: hazard_pipe

---
 rtl/hazard_pipe.sv | 137 +++++++++++++
 tb/tb_hazard_pipe.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_pipe.sv
// Pipeline hazard unit: tracks destination/class of the instructions in EX, MEM and WB,
// raises a load-use style stall for the ID instruction and counts stall cycles.
module hazard_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  A1_ID,
   input  logic [4:0]  A2_ID,
   input  logic [4:0]  A3_ID,
   input  logic [1:0]  Tnew_ID,
   input  logic [1:0]  Tuse_rs,
   input  logic [1:0]  Tuse_rt,
   input  logic        valid_ID,
   output logic [4:0]  A1_EX,
   output logic [4:0]  A2_EX,
   output logic [4:0]  A2_MEM,
   output logic [4:0]  A3_EX,
   output logic [4:0]  A3_MEM,
   output logic [4:0]  A3_WB,
   output logic [1:0]  Tnew_EX,
   output logic [1:0]  Tnew_MEM,
   output logic [1:0]  Tnew_WB,
   output logic        stall,
   output logic [15:0] stall_cnt
);

   localparam logic [1:0]  TNEW_NONE = 2'd3;
   localparam logic [1:0]  TUSE_NONE = 2'd3;
   localparam logic [2:0]  STAGE_EX  = 3'd1;
   localparam logic [2:0]  STAGE_MEM = 3'd2;
   localparam logic [15:0] CNT_MAX   = 16'hFFFF;

   logic [4:0]  a1_ex_q, a1_ex_d;
   logic [4:0]  a2_ex_q, a2_ex_d;
   logic [4:0]  a3_ex_q, a3_ex_d;
   logic [1:0]  tnew_ex_q, tnew_ex_d;
   logic [4:0]  a2_mem_q, a3_mem_q, a3_wb_q;
   logic [1:0]  tnew_mem_q, tnew_wb_q;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic id_producer;
   logic rs_ex_match, rt_ex_match;
   logic rs_hazard, rt_hazard;

   // A producer of class tnew sitting in stage 'stage' blocks an operand needed
   // at stage tuse when its result cannot be forwarded in time.
   function automatic logic stage_term(input logic [4:0] src,
                                       input logic [1:0] tuse,
                                       input logic [4:0] a3,
                                       input logic [1:0] tnew,
                                       input logic [2:0] stage);
      stage_term = (tuse != TUSE_NONE) && (src != 5'd0) && (a3 == src) &&
                   (tnew != TNEW_NONE) && ({1'b0, tnew} >= (stage + {1'b0, tuse}));
   endfunction

   assign id_producer = valid_ID && (A3_ID != 5'd0) && (Tnew_ID != TNEW_NONE);

   // The youngest writer (EX) of an operand hides any older writer in MEM.
   assign rs_ex_match = (A1_ID != 5'd0) && (a3_ex_q == A1_ID) && (tnew_ex_q != TNEW_NONE);
   assign rt_ex_match = (A2_ID != 5'd0) && (a3_ex_q == A2_ID) && (tnew_ex_q != TNEW_NONE);

   always_comb begin
      rs_hazard = 1'b0;
      rt_hazard = 1'b0;
      if (rs_ex_match) begin
         rs_hazard = stage_term(A1_ID, Tuse_rs, a3_ex_q, tnew_ex_q, STAGE_EX);
      end else begin
         rs_hazard = stage_term(A1_ID, Tuse_rs, a3_mem_q, tnew_mem_q, STAGE_MEM);
      end
      if (rt_ex_match) begin
         rt_hazard = stage_term(A2_ID, Tuse_rt, a3_ex_q, tnew_ex_q, STAGE_EX);
      end else begin
         rt_hazard = stage_term(A2_ID, Tuse_rt, a3_mem_q, tnew_mem_q, STAGE_MEM);
      end
   end

   assign stall = valid_ID && (rs_hazard || rt_hazard);

   always_comb begin
      a1_ex_d   = 5'd0;
      a2_ex_d   = 5'd0;
      a3_ex_d   = 5'd0;
      tnew_ex_d = TNEW_NONE;
      if (!stall) begin
         a1_ex_d = valid_ID ? A1_ID : 5'd0;
         a2_ex_d = valid_ID ? A2_ID : 5'd0;
         if (id_producer) begin
            a3_ex_d   = A3_ID;
            tnew_ex_d = Tnew_ID;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a1_ex_q     <= 5'd0;
         a2_ex_q     <= 5'd0;
         a3_ex_q     <= 5'd0;
         tnew_ex_q   <= TNEW_NONE;
         a2_mem_q    <= 5'd0;
         a3_mem_q    <= 5'd0;
         tnew_mem_q  <= TNEW_NONE;
         a3_wb_q     <= 5'd0;
         tnew_wb_q   <= TNEW_NONE;
         stall_cnt_q <= 16'd0;
      end else begin
         a1_ex_q     <= a1_ex_d;
         a2_ex_q     <= a2_ex_d;
         a3_ex_q     <= a3_ex_d;
         tnew_ex_q   <= tnew_ex_d;
         a2_mem_q    <= a2_ex_q;
         a3_mem_q    <= a3_ex_q;
         tnew_mem_q  <= tnew_ex_q;
         a3_wb_q     <= a3_mem_q;
         tnew_wb_q   <= tnew_mem_q;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign A1_EX     = a1_ex_q;
   assign A2_EX     = a2_ex_q;
   assign A3_EX     = a3_ex_q;
   assign Tnew_EX   = tnew_ex_q;
   assign A2_MEM    = a2_mem_q;
   assign A3_MEM    = a3_mem_q;
   assign Tnew_MEM  = tnew_mem_q;
   assign A3_WB     = a3_wb_q;
   assign Tnew_WB   = tnew_wb_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_pipe.sv
// Directed bench for hazard_pipe: a per-cycle reference model of the stage contents
// plus hand-computed stall counts and stage values for each scenario.
module tb_hazard_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  A1_ID = 5'd0, A2_ID = 5'd0, A3_ID = 5'd0;
   logic [1:0]  Tnew_ID = 2'd3, Tuse_rs = 2'd3, Tuse_rt = 2'd3;
   logic        valid_ID = 1'b0;
   logic [4:0]  A1_EX, A2_EX, A2_MEM, A3_EX, A3_MEM, A3_WB;
   logic [1:0]  Tnew_EX, Tnew_MEM, Tnew_WB;
   logic        stall;
   logic [15:0] stall_cnt;

   int vec_cnt = 0;
   int err_cnt = 0;

   hazard_pipe dut (
      .clk(clk), .rst(rst),
      .A1_ID(A1_ID), .A2_ID(A2_ID), .A3_ID(A3_ID),
      .Tnew_ID(Tnew_ID), .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt),
      .valid_ID(valid_ID),
      .A1_EX(A1_EX), .A2_EX(A2_EX), .A2_MEM(A2_MEM),
      .A3_EX(A3_EX), .A3_MEM(A3_MEM), .A3_WB(A3_WB),
      .Tnew_EX(Tnew_EX), .Tnew_MEM(Tnew_MEM), .Tnew_WB(Tnew_WB),
      .stall(stall), .stall_cnt(stall_cnt)
   );

   // clock / reset
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [4:0] a1;
      logic [4:0] a2;
      logic [4:0] a3;
      logic [1:0] tnew;
   } rec_t;

   localparam rec_t BUBBLE = '{a1: 5'd0, a2: 5'd0, a3: 5'd0, tnew: 2'd3};

   rec_t        m_pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
   logic [15:0] m_cnt;
   int          preset_req  = 0;
   int          preset_seen = 0;

   // Does operand src (needed at stage tuse) wait on the youngest in-flight writer?
   function automatic logic operand_blocked(input logic [4:0] src, input logic [1:0] tuse);
      if (tuse == 2'd3 || src == 5'd0) return 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (m_pipe[i].a3 == src) begin
            return int'(m_pipe[i].tnew) >= (i + 1) + int'(tuse);
         end
      end
      return 1'b0;
   endfunction

   function automatic logic model_stall();
      if (!valid_ID) return 1'b0;
      return operand_blocked(A1_ID, Tuse_rs) || operand_blocked(A2_ID, Tuse_rt);
   endfunction

   function automatic rec_t id_record();
      rec_t r;
      r = BUBBLE;
      if (valid_ID) begin
         r.a1 = A1_ID;
         r.a2 = A2_ID;
         if (A3_ID != 5'd0 && Tnew_ID != 2'd3) begin
            r.a3   = A3_ID;
            r.tnew = Tnew_ID;
         end
      end
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) m_pipe[i] = BUBBLE;
         m_cnt = 16'd0;
      end else begin : advance
         logic s;
         s = model_stall();
         m_pipe[2] = m_pipe[1];
         m_pipe[1] = m_pipe[0];
         m_pipe[0] = s ? BUBBLE : id_record();
         if (preset_req != preset_seen) begin
            m_cnt       = 16'hFFF0;
            preset_seen = preset_req;
         end else if (s && m_cnt != 16'hFFFF) begin
            m_cnt = m_cnt + 16'd1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("m_stall",     16'(stall),     16'(model_stall()));
            check("m_A1_EX",     16'(A1_EX),     16'(m_pipe[0].a1));
            check("m_A2_EX",     16'(A2_EX),     16'(m_pipe[0].a2));
            check("m_A3_EX",     16'(A3_EX),     16'(m_pipe[0].a3));
            check("m_Tnew_EX",   16'(Tnew_EX),   16'(m_pipe[0].tnew));
            check("m_A2_MEM",    16'(A2_MEM),    16'(m_pipe[1].a2));
            check("m_A3_MEM",    16'(A3_MEM),    16'(m_pipe[1].a3));
            check("m_Tnew_MEM",  16'(Tnew_MEM),  16'(m_pipe[1].tnew));
            check("m_A3_WB",     16'(A3_WB),     16'(m_pipe[2].a3));
            check("m_Tnew_WB",   16'(Tnew_WB),   16'(m_pipe[2].tnew));
            check("m_stall_cnt", stall_cnt,      m_cnt);
         end
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_A1_EX"},    16'(A1_EX),    16'd0);
      check({tag, "_A2_EX"},    16'(A2_EX),    16'd0);
      check({tag, "_A2_MEM"},   16'(A2_MEM),   16'd0);
      check({tag, "_A3_EX"},    16'(A3_EX),    16'd0);
      check({tag, "_A3_MEM"},   16'(A3_MEM),   16'd0);
      check({tag, "_A3_WB"},    16'(A3_WB),    16'd0);
      check({tag, "_Tnew_EX"},  16'(Tnew_EX),  16'd3);
      check({tag, "_Tnew_MEM"}, 16'(Tnew_MEM), 16'd3);
      check({tag, "_Tnew_WB"},  16'(Tnew_WB),  16'd3);
      check({tag, "_stall"},    16'(stall),    16'd0);
      check({tag, "_cnt"},      stall_cnt,     16'd0);
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                        input logic [1:0] tn, input logic [1:0] tr, input logic [1:0] tt,
                        input logic v);
      A1_ID = a1; A2_ID = a2; A3_ID = a3;
      Tnew_ID = tn; Tuse_rs = tr; Tuse_rt = tt; valid_ID = v;
   endtask

   // Present one instruction in ID and hold it until it advances; n = stall cycles seen.
   task automatic issue(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                        input logic [1:0] tn, input logic [1:0] tr, input logic [1:0] tt,
                        input logic v, output int n);
      @(negedge clk);
      #2;
      drive(a1, a2, a3, tn, tr, tt, v);
      #1;
      n = 0;
      while (stall && n < 8) begin
         @(negedge clk);
         #3;
         n++;
      end
   endtask

   task automatic nops(input int k);
      int n;
      for (int i = 0; i < k; i++) issue(5'd0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd3, 1'b0, n);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int n;
      fork
         monitor();
      join_none

      repeat (2) @(negedge clk);
      #1;
      check_reset_values("rst_init");
      #1;
      rst = 1'b0;

      // ALU writes $5, branch reads $5 in ID: one bubble
      issue(5'd1, 5'd2, 5'd5, 2'd1, 2'd1, 2'd1, 1'b1, n);
      check("alu_prod_n", 16'(n), 16'd0);
      issue(5'd5, 5'd6, 5'd0, 2'd3, 2'd0, 2'd0, 1'b1, n);
      check("alu_beq_n", 16'(n), 16'd1);
      check("alu_beq_A3_EX", 16'(A3_EX), 16'd0);
      check("alu_beq_Tnew_EX", 16'(Tnew_EX), 16'd3);
      check("alu_beq_cnt", stall_cnt, 16'd1);
      nops(3);

      // load $8, consumer needs rt in EX: one bubble
      issue(5'd9, 5'd0, 5'd8, 2'd2, 2'd1, 2'd3, 1'b1, n);
      issue(5'd1, 5'd8, 5'd10, 2'd1, 2'd1, 2'd1, 1'b1, n);
      check("ld_use1_n", 16'(n), 16'd1);
      check("ld_use1_cnt", stall_cnt, 16'd2);
      nops(3);

      // load $8, consumer needs rt in ID: two bubbles
      issue(5'd9, 5'd0, 5'd8, 2'd2, 2'd1, 2'd3, 1'b1, n);
      issue(5'd1, 5'd8, 5'd10, 2'd1, 2'd1, 2'd0, 1'b1, n);
      check("ld_use0_n", 16'(n), 16'd2);
      check("ld_use0_cnt", stall_cnt, 16'd4);
      nops(3);

      // lui result is available immediately
      issue(5'd0, 5'd0, 5'd3, 2'd0, 2'd3, 2'd3, 1'b1, n);
      issue(5'd3, 5'd0, 5'd11, 2'd1, 2'd0, 2'd3, 1'b1, n);
      check("lui_n", 16'(n), 16'd0);
      check("lui_A3_EX", 16'(A3_EX), 16'd3);
      check("lui_Tnew_EX", 16'(Tnew_EX), 16'd0);
      nops(3);

      // write to $0 is not a producer; reader of $0 never stalls
      issue(5'd1, 5'd2, 5'd0, 2'd1, 2'd1, 2'd1, 1'b1, n);
      issue(5'd0, 5'd0, 5'd12, 2'd1, 2'd0, 2'd0, 1'b1, n);
      check("r0_n", 16'(n), 16'd0);
      check("r0_A3_EX", 16'(A3_EX), 16'd0);
      check("r0_Tnew_EX", 16'(Tnew_EX), 16'd3);
      check("r0_A1_EX", 16'(A1_EX), 16'd1);
      nops(3);

      // invalid writer of $7 is a bubble
      issue(5'd7, 5'd7, 5'd7, 2'd1, 2'd1, 2'd1, 1'b0, n);
      issue(5'd7, 5'd0, 5'd13, 2'd1, 2'd0, 2'd3, 1'b1, n);
      check("inv_n", 16'(n), 16'd0);
      check("inv_A3_EX", 16'(A3_EX), 16'd0);
      check("inv_Tnew_EX", 16'(Tnew_EX), 16'd3);
      check("inv_A1_EX", 16'(A1_EX), 16'd0);
      check("inv_A2_EX", 16'(A2_EX), 16'd0);
      nops(3);

      // load $4, ALU $4, branch on $4: the ALU in EX decides (one bubble)
      issue(5'd1, 5'd2, 5'd4, 2'd2, 2'd1, 2'd1, 1'b1, n);
      issue(5'd1, 5'd2, 5'd4, 2'd1, 2'd1, 2'd1, 1'b1, n);
      check("young_add_n", 16'(n), 16'd0);
      issue(5'd4, 5'd0, 5'd0, 2'd3, 2'd0, 2'd3, 1'b1, n);
      check("young_beq_n", 16'(n), 16'd1);
      check("young_cnt", stall_cnt, 16'd5);
      nops(3);

      // load $9 then lui $9: the lui in EX hides the load in MEM
      issue(5'd1, 5'd2, 5'd9, 2'd2, 2'd1, 2'd1, 1'b1, n);
      issue(5'd0, 5'd0, 5'd9, 2'd0, 2'd3, 2'd3, 1'b1, n);
      issue(5'd0, 5'd9, 5'd14, 2'd1, 2'd3, 2'd0, 1'b1, n);
      check("hide_n", 16'(n), 16'd0);
      nops(3);

      // operand needed in MEM after a load: no stall
      issue(5'd1, 5'd2, 5'd15, 2'd2, 2'd1, 2'd1, 1'b1, n);
      issue(5'd0, 5'd15, 5'd16, 2'd1, 2'd3, 2'd2, 1'b1, n);
      check("use2_n", 16'(n), 16'd0);
      // Tnew=3 with a nonzero destination is not a producer
      issue(5'd1, 5'd2, 5'd20, 2'd3, 2'd1, 2'd1, 1'b1, n);
      issue(5'd20, 5'd20, 5'd21, 2'd1, 2'd0, 2'd0, 1'b1, n);
      check("nowr_n", 16'(n), 16'd0);
      check("nowr_A3_EX", 16'(A3_EX), 16'd0);
      check("nowr_Tnew_EX", 16'(Tnew_EX), 16'd3);
      check("mid_cnt", stall_cnt, 16'd5);
      nops(3);

      // saturation: preload the counter close to the top, then stall 20 more cycles
      @(negedge clk);
      #2;
      force dut.stall_cnt_q = 16'hFFF0;
      preset_req++;
      @(posedge clk);
      #1;
      release dut.stall_cnt_q;
      for (int i = 0; i < 10; i++) begin
         issue(5'd0, 5'd0, 5'd8, 2'd2, 2'd1, 2'd3, 1'b1, n);
         issue(5'd8, 5'd0, 5'd10, 2'd1, 2'd0, 2'd3, 1'b1, n);
         check("sat_pair_n", 16'(n), 16'd2);
      end
      check("sat_cnt", stall_cnt, 16'hFFFF);

      // reset in the middle of a load-use stall
      issue(5'd0, 5'd0, 5'd8, 2'd2, 2'd1, 2'd3, 1'b1, n);
      @(negedge clk);
      #2;
      drive(5'd8, 5'd0, 5'd10, 2'd1, 2'd0, 2'd3, 1'b1);
      #1;
      check("pre_rst_stall", 16'(stall), 16'd1);
      rst = 1'b1;
      #1;
      check_reset_values("rst_mid");
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("post_rst_stall", 16'(stall), 16'd0);
      @(negedge clk);
      #3;
      check("post_rst_cnt", stall_cnt, 16'd0);
      check("post_rst_A1_EX", 16'(A1_EX), 16'd8);
      check("post_rst_A3_EX", 16'(A3_EX), 16'd10);
      nops(4);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
